// File: rtl/exibe_sequencia_leds.sv
// Plays the stored game sequence on the LEDs, from address 0 up to a latched round limit.
// Each entry is lit for T_ON cycles and then dark for T_OFF cycles. The ROM read is synchronous.
module exibe_sequencia_leds #(
  parameter int T_ON   = 500,
  parameter int T_OFF  = 250,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  // Handshake: iniciar is a level request that is accepted only in INICIAL. There is no ready signal.
  // pronto is a single-cycle completion strobe that the consumer must catch, because nothing holds it.
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    LE      = 4'd1,
    CAPTURA = 4'd2,
    MOSTRA  = 4'd3,
    APAGA   = 4'd4,
    FIM     = 4'd5
  } estado_t;

  estado_t           estado, estado_prox;
  logic [CNT_W-1:0]  tempo;
  logic [ADDR_W-1:0] limite_reg;
  logic              fim_on, fim_off, ultimo;

  assign fim_on  = (tempo == CNT_W'(T_ON - 1));
  assign fim_off = (tempo == CNT_W'(T_OFF - 1));
  assign ultimo  = (endereco == limite_reg);

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL: if (iniciar) estado_prox = LE;
      LE:      estado_prox = CAPTURA;
      CAPTURA: estado_prox = MOSTRA;
      MOSTRA:  if (fim_on) estado_prox = APAGA;
      APAGA:   if (fim_off) estado_prox = ultimo ? FIM : LE;
      FIM:     estado_prox = INICIAL;
      default: estado_prox = INICIAL;
    endcase
  end

  // The datapath registers follow the current state. ROM data is captured one cycle after LE.
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco   <= '0;
      limite_reg <= '0;
      leds       <= 4'b0000;
      tempo      <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            endereco   <= '0;
            limite_reg <= limite;
          end
        end
        CAPTURA: begin
          leds  <= dado_memoria;
          tempo <= '0;
        end
        MOSTRA: begin
          if (fim_on) begin
            leds  <= 4'b0000;
            tempo <= '0;
          end else begin
            tempo <= tempo + 1'b1;
          end
        end
        APAGA: begin
          if (fim_off) begin
            tempo <= '0;
            if (!ultimo) endereco <= endereco + 1'b1;
          end else begin
            tempo <= tempo + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign exibindo  = (estado != INICIAL) && (estado != FIM);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia_leds.sv
// Bench for exibe_sequencia_leds. A reference trace of each playback is queued when it is started,
// and a monitor compares the DUT cycle by cycle whenever the DUT is busy or strobing pronto.
module tb_exibe_sequencia_leds;

  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;
  localparam int ADDR_W = 4;
  localparam int W      = 14;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              iniciar = 1'b0;
  logic [ADDR_W-1:0] limite = '0;
  logic [3:0]        dado_memoria;
  logic [ADDR_W-1:0] endereco;
  logic [3:0]        leds;
  logic              exibindo;
  logic              pronto;
  logic [3:0]        db_estado;

  logic [3:0] rom [16];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  exibe_sequencia_leds #(.T_ON(T_ON), .T_OFF(T_OFF), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
    .dado_memoria(dado_memoria), .endereco(endereco), .leds(leds),
    .exibindo(exibindo), .pronto(pronto), .db_estado(db_estado)
  );

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h4; rom[3] = 4'h8;
    rom[4] = 4'h4; rom[5] = 4'h2; rom[6] = 4'h1; rom[7] = 4'h1;
    rom[8] = 4'h2; rom[9] = 4'h2; rom[10] = 4'h4; rom[11] = 4'h4;
    rom[12] = 4'h8; rom[13] = 4'h8; rom[14] = 4'h1; rom[15] = 4'h4;
  end

  // one-cycle synchronous ROM
  always @(posedge clock) dado_memoria <= rom[endereco];

  // reference model: the observable trace of one playback, as {exibindo, pronto, state, leds, endereco}
  task automatic push_playback(input int lim);
    for (int k = 0; k <= lim; k++) begin
      exp_q.push_back({1'b1, 1'b0, 4'd1, 4'h0, 4'(k)});
      exp_q.push_back({1'b1, 1'b0, 4'd2, 4'h0, 4'(k)});
      for (int t = 0; t < T_ON; t++)  exp_q.push_back({1'b1, 1'b0, 4'd3, rom[k], 4'(k)});
      for (int t = 0; t < T_OFF; t++) exp_q.push_back({1'b1, 1'b0, 4'd4, 4'h0, 4'(k)});
    end
    exp_q.push_back({1'b0, 1'b1, 4'd5, 4'h0, 4'(lim)});
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (mon_en) begin
      if (exibindo || pronto) begin
        logic [W-1:0] got, exp;
        got = {exibindo, pronto, db_estado, leds, endereco};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got=%h with empty expected queue at %0t", got, $time);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL trace: got=%h exp=%h (exib,pronto,state,leds,addr) at %0t", got, exp, $time);
          end
        end
      end else begin
        checks++;
        if (leds !== 4'h0 || db_estado !== 4'd0 || exibindo !== 1'b0 || pronto !== 1'b0) begin
          errors++;
          $display("FAIL idle: leds=%h state=%h exib=%b pronto=%b exp 0,0,0,0 at %0t",
                   leds, db_estado, exibindo, pronto, $time);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 3000) begin
      @(negedge clock);
      cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d entries left, exp 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic start(input int lim);
    iniciar = 1'b1;
    limite  = 4'(lim);
    push_playback(lim);
    @(posedge clock); #1;
    iniciar = 1'b0;
    limite  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int cnt;
    int lim;
    // reset
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    check("reset_endereco", 32'(endereco), 32'd0);
    check("reset_leds", 32'(leds), 32'd0);
    repeat (10) @(posedge clock);
    #1;

    // directed boundaries: single entry, four entries, full sequence without wrap
    start(0);  wait_idle();
    start(3);  wait_idle();
    start(15); wait_idle();

    // randomized rounds with random idle gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      start($urandom_range(0, 15));
      wait_idle();
    end

    // reset during MOSTRA of entry 2, then replay from entry 0
    start(5);
    cnt = 0;
    while (!(db_estado == 4'd3 && endereco == 4'd2) && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    check("reach_mostra2", 32'(cnt < 200), 32'd1);
    #1;
    mon_en = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset_leds", 32'(leds), 32'd0);
    check("midreset_endereco", 32'(endereco), 32'd0);
    check("midreset_state", 32'(db_estado), 32'd0);
    check("midreset_pronto", 32'(pronto), 32'd0);
    mon_en = 1'b1;
    @(posedge clock); #1;
    start(2); wait_idle();

    // iniciar held 5 cycles while limite changes: one playback, latched limite
    iniciar = 1'b1;
    limite  = 4'd2;
    push_playback(2);
    @(posedge clock); #1;
    limite = 4'd9;
    repeat (4) @(posedge clock);
    #1;
    iniciar = 1'b0;
    wait_idle();

    // iniciar held through FIM: immediate second playback after one INICIAL cycle
    lim = 1;
    iniciar = 1'b1;
    limite  = 4'(lim);
    push_playback(lim);
    push_playback(lim);
    repeat ((lim + 1) * (T_ON + T_OFF + 2) + 3) @(posedge clock);
    #1;
    iniciar = 1'b0;
    wait_idle();

    repeat (5) @(posedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
